// File: rtl/time_set_ctrl.sv
// HH:MM time-setting controller: key debounce, press pulses,
// auto-repeat, edit FSM, load strobe and blink.
module time_set_ctrl #(
  parameter int DB_W         = 16,
  parameter int DEBOUNCE     = 1000,
  parameter int REPEAT_DELAY = 30000,
  parameter int REPEAT_RATE  = 8000,
  parameter int BLINK        = 20000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       key_mode,
  input  logic       key_inc,
  input  logic [4:0] cur_hour,
  input  logic [5:0] cur_minute,
  output logic       run_flag,
  output logic [1:0] set_state,
  output logic [4:0] edit_hour,
  output logic [5:0] edit_minute,
  output logic       load,
  output logic       blink
);

  typedef enum logic [1:0] {
    S_RUN  = 2'd0,
    S_HOUR = 2'd1,
    S_MIN  = 2'd2
  } state_e;

  localparam logic [DB_W-1:0] DB_LAST  = DB_W'(DEBOUNCE - 1);
  localparam logic [DB_W-1:0] RP_DLY   = DB_W'(REPEAT_DELAY);
  localparam logic [DB_W-1:0] RP_RATE  = DB_W'(REPEAT_RATE);
  localparam logic [DB_W-1:0] BL_LAST  = DB_W'(BLINK - 1);
  localparam logic [DB_W-1:0] CNT_ONE  = DB_W'(1);

  // key index 0 = mode, 1 = inc
  logic [1:0]      raw;
  logic [1:0]      sync1_q, sync2_q;
  logic [1:0]      db_q, db_d;
  logic [1:0]      db_dly_q;
  logic [1:0]      press_q, press_d;
  logic [DB_W-1:0] db_cnt_q [2];
  logic [DB_W-1:0] db_cnt_d [2];

  state_e          state_q, state_d;
  logic            run_q, run_d;
  logic [4:0]      hour_q, hour_d;
  logic [5:0]      min_q, min_d;
  logic            load_q, load_d;
  logic            blink_q, blink_d;
  logic [DB_W-1:0] blink_cnt_q, blink_cnt_d;
  logic [DB_W-1:0] rep_cnt_q, rep_cnt_d;
  logic            rep_ph_q, rep_ph_d;

  logic            in_set;
  logic            rep_fire;
  logic            mode_ev;
  logic            inc_ev;

  assign raw = {key_inc, key_mode};

  always_comb begin
    for (int k = 0; k < 2; k++) begin
      db_d[k]     = db_q[k];
      db_cnt_d[k] = '0;
      if (sync2_q[k] != db_q[k]) begin
        if (db_cnt_q[k] == DB_LAST) begin
          db_d[k] = sync2_q[k];
        end else begin
          db_cnt_d[k] = db_cnt_q[k] + CNT_ONE;
        end
      end
      press_d[k] = db_q[k] & ~db_dly_q[k];
    end
  end

  assign in_set   = (state_q != S_RUN);
  assign rep_fire = in_set & db_q[1] & ~press_q[1] &
                    (rep_cnt_q == (rep_ph_q ? RP_RATE : RP_DLY));
  assign mode_ev  = press_q[0];
  assign inc_ev   = (press_q[1] | rep_fire) & ~mode_ev;

  always_comb begin
    state_d = state_q;
    run_d   = run_q;
    hour_d  = hour_q;
    min_d   = min_q;
    load_d  = 1'b0;
    unique case (state_q)
      S_RUN: begin
        if (mode_ev) begin
          state_d = S_HOUR;
          hour_d  = cur_hour;
          min_d   = cur_minute;
          run_d   = 1'b0;
        end
      end
      S_HOUR: begin
        if (mode_ev) begin
          state_d = S_MIN;
        end else if (inc_ev) begin
          hour_d = (hour_q >= 5'd23) ? 5'd0 : hour_q + 5'd1;
        end
      end
      S_MIN: begin
        if (mode_ev) begin
          state_d = S_RUN;
          run_d   = 1'b1;
          load_d  = 1'b1;
        end else if (inc_ev) begin
          min_d = (min_q >= 6'd59) ? 6'd0 : min_q + 6'd1;
        end
      end
      default: begin
        state_d = S_RUN;
        run_d   = 1'b1;
      end
    endcase
  end

  // repeat timer restarts on each press and after each repeat
  always_comb begin
    rep_cnt_d = rep_cnt_q + CNT_ONE;
    rep_ph_d  = rep_ph_q;
    if (!in_set || !db_q[1] || state_d != state_q) begin
      rep_cnt_d = '0;
      rep_ph_d  = 1'b0;
    end else if (press_q[1]) begin
      rep_cnt_d = CNT_ONE;
      rep_ph_d  = 1'b0;
    end else if (rep_fire) begin
      rep_cnt_d = CNT_ONE;
      rep_ph_d  = 1'b1;
    end
  end

  always_comb begin
    blink_d     = blink_q;
    blink_cnt_d = blink_cnt_q + CNT_ONE;
    if (state_d == S_RUN || state_d != state_q) begin
      blink_d     = 1'b0;
      blink_cnt_d = '0;
    end else if (blink_cnt_q == BL_LAST) begin
      blink_d     = ~blink_q;
      blink_cnt_d = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      db_q        <= '0;
      db_dly_q    <= '0;
      press_q     <= '0;
      db_cnt_q[0] <= '0;
      db_cnt_q[1] <= '0;
      state_q     <= S_RUN;
      run_q       <= 1'b1;
      hour_q      <= '0;
      min_q       <= '0;
      load_q      <= 1'b0;
      blink_q     <= 1'b0;
      blink_cnt_q <= '0;
      rep_cnt_q   <= '0;
      rep_ph_q    <= 1'b0;
    end else begin
      sync1_q     <= raw;
      sync2_q     <= sync1_q;
      db_q        <= db_d;
      db_dly_q    <= db_q;
      press_q     <= press_d;
      db_cnt_q[0] <= db_cnt_d[0];
      db_cnt_q[1] <= db_cnt_d[1];
      state_q     <= state_d;
      run_q       <= run_d;
      hour_q      <= hour_d;
      min_q       <= min_d;
      load_q      <= load_d;
      blink_q     <= blink_d;
      blink_cnt_q <= blink_cnt_d;
      rep_cnt_q   <= rep_cnt_d;
      rep_ph_q    <= rep_ph_d;
    end
  end

  assign run_flag    = run_q;
  assign set_state   = state_q;
  assign edit_hour   = hour_q;
  assign edit_minute = min_q;
  assign load        = load_q;
  assign blink       = blink_q;

endmodule

// File: tb/tb_time_set_ctrl.sv
// Bench for time_set_ctrl: output-change events are matched
// against a queue of expected {cycle, outputs} entries.
module tb_time_set_ctrl;

  logic       clock = 1'b0;
  logic       reset;
  logic       key_mode;
  logic       key_inc;
  logic [4:0] cur_hour;
  logic [5:0] cur_minute;
  logic       run_flag;
  logic [1:0] set_state;
  logic [4:0] edit_hour;
  logic [5:0] edit_minute;
  logic       load;
  logic       blink;

  time_set_ctrl #(
    .DB_W(16),
    .DEBOUNCE(4),
    .REPEAT_DELAY(20),
    .REPEAT_RATE(5),
    .BLINK(3)
  ) dut (
    .clock(clock),
    .reset(reset),
    .key_mode(key_mode),
    .key_inc(key_inc),
    .cur_hour(cur_hour),
    .cur_minute(cur_minute),
    .run_flag(run_flag),
    .set_state(set_state),
    .edit_hour(edit_hour),
    .edit_minute(edit_minute),
    .load(load),
    .blink(blink)
  );

  always #5 clock = ~clock;

  typedef struct {
    int          cyc;
    logic [14:0] t;
  } exp_t;

  exp_t        sb[$];
  int          cyc = 0;
  int          nvec = 0;
  int          nerr = 0;
  bit          mon_en = 1'b0;
  logic [14:0] prev_t;

  always @(posedge clock) cyc <= cyc + 1;

  function automatic logic [14:0] tup(
    input logic [1:0] s, input logic r,
    input logic [4:0] h, input logic [5:0] mi,
    input logic l);
    return {s, r, h, mi, l};
  endfunction

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    nvec++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h want %0h (cyc %0d)",
               tag, obs, exp, cyc);
    end
  endtask

  task automatic push(input int c, input logic [14:0] t);
    exp_t e;
    e.cyc = c;
    e.t   = t;
    sb.push_back(e);
  endtask

  task automatic mon_step();
    logic [14:0] t;
    exp_t        e;
    t = tup(set_state, run_flag, edit_hour, edit_minute, load);
    if (t !== prev_t) begin
      if (sb.size() == 0) begin
        check("unexpected_evt", t, prev_t);
      end else begin
        e = sb.pop_front();
        check("evt_val", t, e.t);
        check("evt_cyc", cyc, e.cyc);
      end
      prev_t = t;
    end
  endtask

  always @(negedge clock) if (mon_en) mon_step();

  // n = number of output events expected (2 = load pulse + drop)
  task automatic press(input bit m, input bit i, input int n,
                       input logic [14:0] t);
    int   k;
    logic eb;
    k = cyc;
    if (n >= 1) push(k + 8, t);
    if (n == 2) push(k + 9, t & ~15'd1);
    key_mode = m;
    key_inc  = i;
    repeat (6) @(negedge clock);
    key_mode = 1'b0;
    key_inc  = 1'b0;
    repeat (2) @(negedge clock);
    for (int j = 0; j < 7; j++) begin
      if (m) begin
        eb = (t[14:13] != 2'd0) && (((j / 3) % 2) == 1);
        check("blink", blink, eb);
      end
      @(negedge clock);
    end
    repeat (3) @(negedge clock);
  endtask

  task automatic drain(input string tag);
    repeat (4) @(negedge clock);
    check(tag, sb.size(), 0);
  endtask

  initial begin
    int k;
    reset      = 1'b1;
    key_mode   = 1'b0;
    key_inc    = 1'b0;
    cur_hour   = 5'd0;
    cur_minute = 6'd0;
    repeat (3) @(negedge clock);
    check("rst_run", run_flag, 1'b1);
    check("rst_state", set_state, 2'd0);
    check("rst_hour", edit_hour, 5'd0);
    check("rst_min", edit_minute, 6'd0);
    check("rst_load", load, 1'b0);
    check("rst_blink", blink, 1'b0);
    reset = 1'b0;
    @(negedge clock);
    prev_t = tup(2'd0, 1'b1, 5'd0, 6'd0, 1'b0);
    mon_en = 1'b1;

    // full edit 13:45 -> 15:48
    cur_hour   = 5'd13;
    cur_minute = 6'd45;
    press(1, 0, 1, tup(2'd1, 1'b0, 5'd13, 6'd45, 1'b0));
    cur_hour   = 5'd2;
    cur_minute = 6'd7;
    press(0, 1, 1, tup(2'd1, 1'b0, 5'd14, 6'd45, 1'b0));
    press(0, 1, 1, tup(2'd1, 1'b0, 5'd15, 6'd45, 1'b0));
    press(1, 0, 1, tup(2'd2, 1'b0, 5'd15, 6'd45, 1'b0));
    press(0, 1, 1, tup(2'd2, 1'b0, 5'd15, 6'd46, 1'b0));
    press(0, 1, 1, tup(2'd2, 1'b0, 5'd15, 6'd47, 1'b0));
    press(0, 1, 1, tup(2'd2, 1'b0, 5'd15, 6'd48, 1'b0));
    press(1, 0, 2, tup(2'd0, 1'b1, 5'd15, 6'd48, 1'b1));
    drain("pend_edit");

    // inc in RUN does nothing
    press(0, 1, 0, 15'd0);
    drain("pend_run_inc");

    // wrap at 23 and 59
    cur_hour   = 5'd23;
    cur_minute = 6'd59;
    press(1, 0, 1, tup(2'd1, 1'b0, 5'd23, 6'd59, 1'b0));
    press(0, 1, 1, tup(2'd1, 1'b0, 5'd0, 6'd59, 1'b0));
    press(1, 0, 1, tup(2'd2, 1'b0, 5'd0, 6'd59, 1'b0));
    press(0, 1, 1, tup(2'd2, 1'b0, 5'd0, 6'd0, 1'b0));
    press(1, 0, 2, tup(2'd0, 1'b1, 5'd0, 6'd0, 1'b1));
    drain("pend_wrap");

    // bounce: short pulses ignored, clean press counts once
    cur_hour   = 5'd5;
    cur_minute = 6'd10;
    press(1, 0, 1, tup(2'd1, 1'b0, 5'd5, 6'd10, 1'b0));
    for (int r = 0; r < 3; r++) begin
      key_inc = 1'b1;
      repeat (3) @(negedge clock);
      key_inc = 1'b0;
      repeat (3) @(negedge clock);
    end
    repeat (10) @(negedge clock);
    check("bounce_hour", edit_hour, 5'd5);
    press(0, 1, 1, tup(2'd1, 1'b0, 5'd6, 6'd10, 1'b0));
    drain("pend_bounce");

    // mode and inc together: mode wins
    press(1, 1, 1, tup(2'd2, 1'b0, 5'd6, 6'd10, 1'b0));
    drain("pend_simul");

    // auto-repeat in SET_MIN from 10
    k = cyc;
    push(k + 8,  tup(2'd2, 1'b0, 5'd6, 6'd11, 1'b0));
    push(k + 28, tup(2'd2, 1'b0, 5'd6, 6'd12, 1'b0));
    push(k + 33, tup(2'd2, 1'b0, 5'd6, 6'd13, 1'b0));
    push(k + 38, tup(2'd2, 1'b0, 5'd6, 6'd14, 1'b0));
    push(k + 43, tup(2'd2, 1'b0, 5'd6, 6'd15, 1'b0));
    key_inc = 1'b1;
    repeat (40) @(negedge clock);
    key_inc = 1'b0;
    repeat (40) @(negedge clock);
    check("rep_min", edit_minute, 6'd15);
    drain("pend_repeat");

    // reset mid-edit: back to RUN, no load
    k = cyc;
    push(k + 1, tup(2'd0, 1'b1, 5'd0, 6'd0, 1'b0));
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    repeat (10) @(negedge clock);
    check("rst_mid_blink", blink, 1'b0);
    check("rst_mid_run", run_flag, 1'b1);
    drain("pend_reset");

    mon_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
